// File: rtl/regfile_gen.sv
// regfile_gen: parametrised register file for the pipelined datapath.
// One clocked write port, two combinational read ports and a per-register
// pending-write scoreboard. Register 0 always reads as zero and is never
// marked pending.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle write to the read address is forwarded to
//                da/db and masks the matching hazard
//   undefined -> read ports and hazards reflect registered state only
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   RegWrite, rc, dc     write enable, write address, write data
//   ra, rb               read addresses (ports A/B)
//   da, db               read data (combinational)
//   busy_set, busy_addr  mark a register as pending (long-latency producer)
//   hazard_a, hazard_b   read address holds a pending write (combinational)
//   busy_cnt             number of pending registers (registered)
module regfile_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rc,
    input  logic [DATA_W-1:0] dc,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = ADDR_W + 1;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    busy_cnt_q;
    logic [CNT_W-1:0]    busy_cnt_d;

    logic wr_en;
    logic set_en;
    logic set_new;
    logic clr_old;

    // Qualified write/set strobes and their effect on the pending count.
    // A set and write on the same address leaves the register pending, so
    // that write never counts as a clear.
    always_comb begin
        wr_en   = RegWrite && (rc != '0);
        set_en  = busy_set && (busy_addr != '0);
        set_new = set_en && !busy_q[busy_addr];
        clr_old = wr_en && busy_q[rc] && !(set_en && (busy_addr == rc));
    end

    // Next-state for storage, scoreboard and counter; set applied after
    // the write-clear so the newer producer wins.
    always_comb begin
        mem_d      = mem_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_en) begin
            mem_d[rc]  = dc;
            busy_d[rc] = 1'b0;
        end
        if (set_en) begin
            busy_d[busy_addr] = 1'b1;
        end
        case ({set_new, clr_old})
            2'b10:   busy_cnt_d = busy_cnt_q + CNT_W'(1);
            2'b01:   busy_cnt_d = busy_cnt_q - CNT_W'(1);
            default: busy_cnt_d = busy_cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read port A.
    always_comb begin
        da       = (ra == '0) ? '0 : mem_q[ra];
        hazard_a = busy_q[ra] && (ra != '0);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rc == ra)) begin
            da       = dc;
            hazard_a = 1'b0;
        end
`endif
    end

    // Read port B.
    always_comb begin
        db       = (rb == '0) ? '0 : mem_q[rb];
        hazard_b = busy_q[rb] && (rb != '0);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rc == rb)) begin
            db       = dc;
            hazard_b = 1'b0;
        end
`endif
    end

    assign busy_cnt = busy_cnt_q;

endmodule
